// File: rtl/code_angle_sync.sv
// Code-disk edge synchroniser: filters the opto-switch input, measures each code
// interval, finds the zero tooth, and sequences a locked per-code angle index.
module code_angle_sync #(
  parameter int unsigned TOOTH_NUM      = 100,
  parameter int unsigned FILT_CNT       = 8,
  parameter int unsigned TIMEOUT_CLKCNT = 100000,
  parameter int unsigned LOCK_REV_NUM   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_opto_switch,
  output logic        o_code_valid,
  output logic [15:0] o_code_idx,
  output logic [31:0] o_code_period,
  output logic        o_zero_pulse,
  output logic        o_locked,
  output logic        o_err_stall,
  output logic        o_err_slip
);

  localparam int unsigned NORM_NUM = (TOOTH_NUM - 2) * 2;
  localparam int unsigned EDGE_NUM = NORM_NUM + 2;
  localparam int unsigned FCW      = (FILT_CNT > 1) ? $clog2(FILT_CNT) : 1;
  localparam int unsigned RW       = (LOCK_REV_NUM > 1) ? $clog2(LOCK_REV_NUM) : 1;

  typedef enum logic [1:0] {IDLE, SEARCH, VERIFY, LOCKED} state_t;

  state_t          state;
  logic [1:0]      sync_q;
  logic            filt_lvl;
  logic            filt_lvl_d;
  logic [FCW-1:0]  filt_cnt;
  logic [31:0]     period_cnt;
  logic [31:0]     cur;
  logic [31:0]     prev;
  logic            edge_d;
  logic            stall_armed;
  logic [15:0]     idx;
  logic [RW-1:0]   rev_cnt;

  logic            acc;
  logic            stall_hit;
  logic            zero_det;
  logic [15:0]     idx_inc;
  logic            at_norm;
  logic            check;
  logic            slip;
  logic            lock_now;
  logic            emit;

  // Two-flop synchroniser followed by a stability filter; runs in every state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q     <= 2'b00;
      filt_lvl   <= 1'b0;
      filt_lvl_d <= 1'b0;
      filt_cnt   <= '0;
    end else begin
      sync_q     <= {sync_q[0], i_opto_switch};
      filt_lvl_d <= filt_lvl;
      if (sync_q[1] == filt_lvl) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FCW'(FILT_CNT - 1)) begin
        filt_lvl <= sync_q[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FCW'(1);
      end
    end
  end

  assign acc       = (filt_lvl ^ filt_lvl_d) && (state != IDLE);
  assign stall_hit = stall_armed && !acc && (period_cnt >= 32'(TIMEOUT_CLKCNT));

  // Interval measurement: cur/prev are the last two completed code periods.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      period_cnt  <= '0;
      cur         <= '0;
      prev        <= '0;
      edge_d      <= 1'b0;
      stall_armed <= 1'b1;
    end else if (state == IDLE) begin
      period_cnt  <= '0;
      cur         <= '0;
      prev        <= '0;
      edge_d      <= 1'b0;
      stall_armed <= 1'b1;
    end else begin
      edge_d <= acc;
      if (acc) begin
        cur         <= period_cnt;
        prev        <= cur;
        period_cnt  <= 32'd1;
        stall_armed <= 1'b1;
      end else begin
        if (period_cnt != '1) period_cnt <= period_cnt + 32'd1;
        if (stall_hit) stall_armed <= 1'b0;
      end
    end
  end

  // Only the first long interval exceeds 1.5x its predecessor.
  assign zero_det = edge_d && (prev != '0) &&
                    (({2'b00, cur} << 1) > (34'(prev) * 34'd3));
  assign idx_inc  = (idx == 16'(EDGE_NUM - 1)) ? 16'd0 : idx + 16'd1;
  assign at_norm  = (idx_inc == 16'(NORM_NUM));
  assign check    = edge_d && ((state == VERIFY) || (state == LOCKED));
  assign slip     = check && (zero_det != at_norm);
  assign lock_now = check && (state == VERIFY) && zero_det && at_norm &&
                    (rev_cnt == RW'(LOCK_REV_NUM - 1));
  assign emit     = (check && (state == LOCKED) && !slip) || lock_now;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      rev_cnt       <= '0;
      o_code_valid  <= 1'b0;
      o_code_idx    <= '0;
      o_code_period <= '0;
      o_zero_pulse  <= 1'b0;
      o_locked      <= 1'b0;
      o_err_stall   <= 1'b0;
      o_err_slip    <= 1'b0;
    end else begin
      o_code_valid <= 1'b0;
      o_zero_pulse <= 1'b0;
      o_err_stall  <= 1'b0;
      o_err_slip   <= 1'b0;
      if (!i_en) begin
        state    <= IDLE;
        idx      <= '0;
        rev_cnt  <= '0;
        o_locked <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= SEARCH;
          SEARCH: begin
            if (stall_hit) begin
              o_err_stall <= 1'b1;
            end else if (edge_d) begin
              if (zero_det) begin
                idx     <= 16'(NORM_NUM);
                rev_cnt <= '0;
                state   <= VERIFY;
              end else begin
                idx <= idx_inc;
              end
            end
          end
          default: begin
            if (stall_hit) begin
              o_err_stall <= 1'b1;
              o_locked    <= 1'b0;
              rev_cnt     <= '0;
              state       <= SEARCH;
            end else if (edge_d) begin
              idx <= idx_inc;
              if (slip) begin
                o_err_slip <= 1'b1;
                o_locked   <= 1'b0;
                rev_cnt    <= '0;
                state      <= SEARCH;
              end else if (lock_now) begin
                o_locked <= 1'b1;
                state    <= LOCKED;
              end else if ((state == VERIFY) && zero_det) begin
                rev_cnt <= rev_cnt + RW'(1);
              end
            end
          end
        endcase
        if (emit) begin
          o_code_valid  <= 1'b1;
          o_code_idx    <= idx_inc;
          o_code_period <= cur;
          o_zero_pulse  <= at_norm;
        end
      end
    end
  end

endmodule
